data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning number of 32-bit words (power of two, >=4).
REQ-002 SHALL have parameter WAIT, default 2, meaning wait-state cycles per access (0..15).
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  1  access request, sampled only in IDLE.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read; qualified by req.
REQ-007 SHALL have port adr  input  32  byte address from the datapath (data_adr).
REQ-008 SHALL have port wdata  input  32  store data from the datapath (data_out).
REQ-009 SHALL have port rdata  output  32  load data to the datapath (data_in).
REQ-010 SHALL have port ack  output  1  one-cycle pulse marking completion of the accepted access.
REQ-011 SHALL have port busy  output  1  high while an access is accepted and not yet acknowledged.
REQ-012 SHALL have port err  output  1  misalignment flag, valid with ack.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, ACK.
REQ-014 IDLE with req=1 SHALL latch adr, we and wdata, load the wait counter with WAIT, and go to WAIT (or to ACK if WAIT=0).
REQ-015 WAIT SHALL decrement the counter each cycle and go to ACK on the cycle the counter reaches 0.
REQ-016 ACK SHALL assert ack for exactly one cycle and return to IDLE unconditionally.
REQ-017 ack SHALL rise exactly WAIT+1 cycles after the accepting edge; minimum request-to-request spacing is WAIT+2 cycles.
REQ-018 busy SHALL be high in WAIT and ACK and low in IDLE.
REQ-019 req in WAIT or ACK SHALL be ignored; no queuing.
REQ-020 The word index SHALL be latched adr[$clog2(DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo DEPTH*4.
REQ-021 A write SHALL update the latched word on the edge entering ACK; rdata is unchanged by writes.
REQ-022 A read SHALL load rdata on the edge entering ACK; rdata holds until the next completed read.
REQ-023 Latched inputs SHALL make adr/wdata/we changes after acceptance have no effect.

Reset
REQ-024 rst SHALL force IDLE, counter=0, rdata=0, ack=0, busy=0, err=0 immediately.
REQ-025 Reset during WAIT SHALL abort the access with no memory write and no ack.
REQ-026 Memory array contents SHALL NOT be reset.

Configuration
REQ-027 Macro MEM_ALIGN_CHK_EN defined: adr[1:0]!=0 SHALL suppress the write, force rdata=0, and raise err together with ack for that access.
REQ-028 Macro MEM_ALIGN_CHK_EN undefined: adr[1:0] SHALL be ignored and err tied to 0.

Structure
REQ-029 Package mem_pkg SHALL hold the FSM state enum, WORD_W=32 and the WAIT_MAX=15 constant.
REQ-030 The wait counter SHALL be a sub-module wait_counter (load, decrement, zero flag).

Verification
REQ-031 WAIT=2: write req adr=0x10 wdata=0xDEADBEEF, then read adr=0x10 -> ack 3 cycles after each accept, rdata=0xDEADBEEF.
REQ-032 WAIT=0: read of adr=0x0 after write 0x5 -> ack 1 cycle after accept, busy high exactly 1 cycle.
REQ-033 DEPTH=256: write 0x1234 to adr=0x400, read adr=0x0 -> rdata=0x1234 (wrap).
REQ-034 req held high continuously, WAIT=2 -> acks spaced exactly 4 cycles apart, extra reqs ignored.
REQ-035 rst asserted in WAIT of write adr=0x8 wdata=0x77 -> no ack; later read of adr=0x8 returns the prior value.
REQ-036 MEM_ALIGN_CHK_EN: write adr=0x12 -> err=1 with ack, word 0x10 unchanged; undefined -> err=0, word 0x10 written.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder: FSM state encoding,
// data word width and the wait-state counter limits.
package mem_pkg;

    localparam int WORD_W   = 32;
    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = $clog2(WAIT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    // A byte address is misaligned for a word access when its low two bits are set.
    function automatic logic is_misaligned(input logic [1:0] lo_bits);
        return (lo_bits != 2'b00);
    endfunction

endpackage

// File: rtl/wait_counter.sv
// Wait-state down-counter: loads the wait count when an access is accepted,
// counts down once per wait cycle and flags when it has run out.
module wait_counter
    import mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] count_reg;

    // Load takes priority over decrement; the count saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    // Expose the current count and its zero flag.
    always_comb begin
        count = count_reg;
        zero  = (count_reg == '0);
    end

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a simple req/ack handshake with a fixed
// number of wait states per access. One access is in flight at a time;
// requests seen while busy are dropped.
// Optional build macro MEM_ALIGN_CHK_EN: when defined, accesses to a byte
// address with adr[1:0] != 0 do not write, return zero read data and raise
// err alongside ack. When undefined, the low address bits are ignored.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        err
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t state_reg;
    state_t state_next;

    // Request captured at acceptance so later input changes cannot disturb it.
    logic [IDX_W-1:0]  idx_reg;
    logic              we_reg;
    logic [WORD_W-1:0] wdata_reg;
    logic              bad_reg;

    logic [WORD_W-1:0] rdata_reg;
    logic              ack_reg;
    logic              err_reg;

    // Control decoded from the current state.
    logic accept;
    logic access_fire;
    logic cnt_dec;
    logic in_ack;

    // Operands of the access actually being performed this cycle.
    logic [IDX_W-1:0]  acc_idx;
    logic              acc_we;
    logic [WORD_W-1:0] acc_wdata;
    logic              acc_bad;
    logic              mem_wr;

    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;
    logic             cnt_last;

    logic [WORD_W-1:0] mem [DEPTH];

    // Address bits above the memory size always wrap away; the low two bits
    // only matter when the alignment check is built in.
    logic unused_adr_bits;
`ifdef MEM_ALIGN_CHK_EN
    logic [1:0] lo_reg;
    assign unused_adr_bits = ^adr[31:IDX_W+2];
`else
    assign unused_adr_bits = ^{adr[31:IDX_W+2], adr[1:0]};
`endif

    wait_counter u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (CNT_W'(WAIT)),
        .dec      (cnt_dec),
        .count    (cnt_val),
        .zero     (cnt_zero)
    );

    // The wait phase ends on the cycle whose decrement takes the count to zero.
    assign cnt_last = cnt_zero || (cnt_val == CNT_W'(1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE -> WAIT -> ACK -> IDLE, skipping WAIT when there are no wait states.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    state_next = (WAIT == 0) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_last) begin
                    state_next = ST_ACK;
                end
            end
            ST_ACK: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output/control decode from the current state.
    always_comb begin
        accept      = 1'b0;
        access_fire = 1'b0;
        cnt_dec     = 1'b0;
        in_ack      = 1'b0;
        busy        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                accept      = req;
                access_fire = req && (WAIT == 0);
            end
            ST_WAIT: begin
                busy        = 1'b1;
                cnt_dec     = 1'b1;
                access_fire = cnt_last;
            end
            ST_ACK: begin
                busy   = 1'b1;
                in_ack = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Access operands: with zero wait states the access happens on the accepting
    // edge itself, so the live inputs are used; otherwise the captured copy.
    always_comb begin
        if (state_reg == ST_IDLE) begin
            acc_idx   = adr[IDX_W+1:2];
            acc_we    = we;
            acc_wdata = wdata;
`ifdef MEM_ALIGN_CHK_EN
            acc_bad   = is_misaligned(adr[1:0]);
`else
            acc_bad   = 1'b0;
`endif
        end else begin
            acc_idx   = idx_reg;
            acc_we    = we_reg;
            acc_wdata = wdata_reg;
`ifdef MEM_ALIGN_CHK_EN
            acc_bad   = is_misaligned(lo_reg);
`else
            acc_bad   = 1'b0;
`endif
        end
        // A reset arriving on the access edge must not leave a write behind.
        mem_wr = access_fire && acc_we && !acc_bad && !rst;
    end

    // Capture the request on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg   <= '0;
            we_reg    <= 1'b0;
            wdata_reg <= '0;
`ifdef MEM_ALIGN_CHK_EN
            lo_reg    <= 2'b00;
`endif
        end else if (accept) begin
            idx_reg   <= adr[IDX_W+1:2];
            we_reg    <= we;
            wdata_reg <= wdata;
`ifdef MEM_ALIGN_CHK_EN
            lo_reg    <= adr[1:0];
`endif
        end
    end

    // Memory array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    // Registered read on the edge entering ACK; held until the next completed read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_reg <= '0;
        end else if (access_fire && !acc_we) begin
            rdata_reg <= acc_bad ? '0 : mem[acc_idx];
        end
    end

    // Remember whether the access in flight was misaligned so err lines up with ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bad_reg <= 1'b0;
        end else if (access_fire) begin
            bad_reg <= acc_bad;
        end
    end

    // One-cycle completion pulse produced on leaving ACK, with err qualified by it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_reg <= 1'b0;
            err_reg <= 1'b0;
        end else begin
            ack_reg <= in_ack;
            err_reg <= in_ack && bad_reg;
        end
    end

    assign rdata = rdata_reg;
    assign ack   = ack_reg;
    assign err   = err_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (WAIT=0 and WAIT=2, DEPTH=256)
// share one stimulus stream. A cycle-level transaction model predicts
// ack/busy/err/rdata for both every cycle; directed literal checks pin the model.
module tb_data_mem_responder;

    localparam int IDX_W = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;

    logic [31:0] rdata_w0, rdata_w2;
    logic        ack_w0, ack_w2;
    logic        busy_w0, busy_w2;
    logic        err_w0, err_w2;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model state per instance: index 0 is WAIT=0, index 1 is WAIT=2.
    int          wt[2]      = '{0, 2};
    int          free_at[2] = '{0, 0};
    int          acc_at[2]  = '{-1, -1};
    int          rd_at[2]   = '{-1, -1};
    int          ack_at[2]  = '{-1, -1};
    bit          pend[2]    = '{0, 0};
    bit          p_we[2];
    logic [31:0] p_adr[2];
    logic [31:0] p_wd[2];
    logic [31:0] rd_m[2]    = '{32'h0, 32'h0};
    bit          bad_m[2]   = '{0, 0};
    logic [31:0] mmem[2][256];

    // Observed statistics used by the directed checks.
    int          ack_cnt[2]  = '{0, 0};
    int          last_ack[2] = '{-1, -1};
    int          prev_ack[2] = '{-1, -1};
    int          busy_cnt[2] = '{0, 0};
    logic        last_err[2] = '{1'b0, 1'b0};

    data_mem_responder #(.DEPTH(256), .WAIT(0)) dut_w0 (
        .clk(clk), .rst(rst), .req(req), .we(we), .adr(adr), .wdata(wdata),
        .rdata(rdata_w0), .ack(ack_w0), .busy(busy_w0), .err(err_w0)
    );

    data_mem_responder #(.DEPTH(256), .WAIT(2)) dut_w2 (
        .clk(clk), .rst(rst), .req(req), .we(we), .adr(adr), .wdata(wdata),
        .rdata(rdata_w2), .ack(ack_w2), .busy(busy_w2), .err(err_w2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s dut_w%0d cyc=%0d got=%h want=%h", nm, wt[d], cyc, got, want);
        end
    endtask

    // Model update at each edge, then compare all outputs 1 time unit later.
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                pend[d]    = 1'b0;
                acc_at[d]  = -1;
                ack_at[d]  = -1;
                free_at[d] = 0;
                rd_m[d]    = 32'h0;
            end else begin
                if (req && cyc >= free_at[d]) begin
                    p_we[d]    = we;
                    p_adr[d]   = adr;
                    p_wd[d]    = wdata;
                    acc_at[d]  = cyc;
                    rd_at[d]   = cyc + wt[d];
                    ack_at[d]  = cyc + wt[d] + 1;
                    free_at[d] = cyc + wt[d] + 2;
                    pend[d]    = 1'b1;
                end
                if (pend[d] && cyc == rd_at[d]) begin
`ifdef MEM_ALIGN_CHK_EN
                    bad_m[d] = (p_adr[d] % 4) != 0;
`else
                    bad_m[d] = 1'b0;
`endif
                    if (p_we[d]) begin
                        if (!bad_m[d]) mmem[d][(p_adr[d] / 4) % 256] = p_wd[d];
                    end else begin
                        rd_m[d] = bad_m[d] ? 32'h0 : mmem[d][(p_adr[d] / 4) % 256];
                    end
                    pend[d] = 1'b0;
                end
            end
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            logic        a_ack, a_busy, a_err, e_ack, e_busy;
            logic [31:0] a_rd;
            a_ack  = (d == 0) ? ack_w0   : ack_w2;
            a_busy = (d == 0) ? busy_w0  : busy_w2;
            a_err  = (d == 0) ? err_w0   : err_w2;
            a_rd   = (d == 0) ? rdata_w0 : rdata_w2;
            e_ack  = (cyc == ack_at[d]);
            e_busy = (acc_at[d] >= 0) && (cyc >= acc_at[d]) && (cyc < ack_at[d]);
            chk("model_ack",   d, {31'b0, a_ack},  {31'b0, e_ack});
            chk("model_busy",  d, {31'b0, a_busy}, {31'b0, e_busy});
            chk("model_err",   d, {31'b0, a_err},  {31'b0, e_ack && bad_m[d]});
            chk("model_rdata", d, a_rd, rd_m[d]);
            if (a_busy) busy_cnt[d]++;
            if (a_ack) begin
                ack_cnt[d]++;
                prev_ack[d] = last_ack[d];
                last_ack[d] = cyc;
                last_err[d] = a_err;
            end
        end
    end

    // One request pulse; inputs are scrambled right after acceptance.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] wd, output int acc);
        @(negedge clk);
        req = 1'b1; we = w; adr = a; wdata = wd;
        acc = cyc + 1;
        @(negedge clk);
        req = 1'b0; we = ~w; adr = 32'hFFFF_FFFC; wdata = 32'hBAD0_BAD0;
        repeat (4) @(negedge clk);
        $display("[TB] txn we=%0d adr=%h wdata=%h acc=%0d ack_w0=%0d ack_w2=%0d rdata_w0=%h rdata_w2=%h",
                 w, a, wd, acc, last_ack[0], last_ack[1], rdata_w0, rdata_w2);
    endtask

    initial begin
        int acc, n0, n2, b0, b2;
        rst = 1'b1; req = 1'b0; we = 1'b0; adr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_rdata", 1, rdata_w2, 32'h0);
        chk("rst_ack",   1, {31'b0, ack_w2},  32'h0);
        chk("rst_busy",  1, {31'b0, busy_w2}, 32'h0);
        chk("rst_err",   1, {31'b0, err_w2},  32'h0);
        rst = 1'b0;

        // Write then read back with WAIT=2 and WAIT=0 latency.
        issue(1'b1, 32'h10, 32'hDEADBEEF, acc);
        chk("wr_ack_lat", 1, last_ack[1], acc + 3);
        chk("wr_ack_lat", 0, last_ack[0], acc + 1);
        issue(1'b0, 32'h10, 32'h0, acc);
        chk("rd_ack_lat", 1, last_ack[1], acc + 3);
        chk("rd_data",    1, rdata_w2, 32'hDEADBEEF);
        chk("rd_data",    0, rdata_w0, 32'hDEADBEEF);

        // Zero-wait read: busy for exactly one cycle.
        issue(1'b1, 32'h0, 32'h5, acc);
        b0 = busy_cnt[0]; b2 = busy_cnt[1];
        issue(1'b0, 32'h0, 32'h0, acc);
        chk("rd_w0_data", 0, rdata_w0, 32'h5);
        chk("busy_len",   0, busy_cnt[0] - b0, 1);
        chk("busy_len",   1, busy_cnt[1] - b2, 3);

        // Address wrap modulo DEPTH*4.
        issue(1'b1, 32'h400, 32'h1234, acc);
        issue(1'b0, 32'h0, 32'h0, acc);
        chk("wrap_data", 1, rdata_w2, 32'h1234);
        chk("wrap_data", 0, rdata_w0, 32'h1234);

        // Reset in the middle of a WAIT=2 write aborts it.
        issue(1'b1, 32'h8, 32'h55, acc);
        @(negedge clk);
        req = 1'b1; we = 1'b1; adr = 32'h8; wdata = 32'h77;
        @(negedge clk);
        req = 1'b0;
        rst = 1'b1;
        n2 = ack_cnt[1];
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_no_ack", 1, ack_cnt[1], n2);
        issue(1'b0, 32'h8, 32'h0, acc);
        chk("rst_keep_mem", 1, rdata_w2, 32'h55);
        chk("rst_keep_mem", 0, rdata_w0, 32'h77);

        // Misaligned write to 0x12.
        issue(1'b1, 32'h12, 32'hAAAA5555, acc);
`ifdef MEM_ALIGN_CHK_EN
        chk("misal_err", 1, {31'b0, last_err[1]}, 32'h1);
`else
        chk("misal_err", 1, {31'b0, last_err[1]}, 32'h0);
`endif
        issue(1'b0, 32'h10, 32'h0, acc);
`ifdef MEM_ALIGN_CHK_EN
        chk("misal_word", 1, rdata_w2, 32'hDEADBEEF);
`else
        chk("misal_word", 1, rdata_w2, 32'hAAAA5555);
`endif

        // Captured inputs: scrambled after acceptance, word 0x20 still gets 0x1.
        issue(1'b1, 32'h20, 32'h1, acc);
        issue(1'b0, 32'h20, 32'h0, acc);
        chk("latched_in", 1, rdata_w2, 32'h1);

        // req held high: WAIT=2 acks every 4 cycles, WAIT=0 every 2.
        n0 = ack_cnt[0]; n2 = ack_cnt[1];
        @(negedge clk);
        req = 1'b1; we = 1'b0; adr = 32'h0; wdata = 32'h0;
        repeat (14) @(negedge clk);
        req = 1'b0;
        repeat (5) @(negedge clk);
        chk("held_cnt",     1, ack_cnt[1] - n2, 4);
        chk("held_cnt",     0, ack_cnt[0] - n0, 7);
        chk("held_spacing", 1, last_ack[1] - prev_ack[1], 4);
        chk("held_spacing", 0, last_ack[0] - prev_ack[0], 2);
        $display("[TB] held req: acks_w0=%0d acks_w2=%0d", ack_cnt[0] - n0, ack_cnt[1] - n2);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
